alu_flag_stage: RTL and testbench

- Registered output stage directly downstream of the 4-bit add/subtract unit.
- Captures the sum and carry taps each cycle and derives the N, Z, C and V flags.
- Buffers results in a 2-entry skid buffer with valid/ready handshakes on both sides, so the adder path is cut at a register boundary with full throughput.
- Feeds the ALU result mux and the status register.

---
 rtl/alu_flag_stage_pkg.sv | 25 ++
 rtl/alu_flag_stage_if.sv | 36 +++
 rtl/alu_flag_stage_calc.sv | 26 ++
 rtl/alu_flag_stage.sv | 142 ++++++++++++++
 tb/tb_alu_flag_stage.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_flag_stage_pkg.sv
// Shared types for the ALU flag output stage: flag record, skid-buffer states
// and the overflow helper used by the flag calculator.
package alu_pkg;

  localparam int FLAG_W = 4;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  // Two's-complement overflow: carry into the MSB differs from carry out of it.
  function automatic logic signed_ovf(input logic c_out, input logic c_msb_in);
    return c_out ^ c_msb_in;
  endfunction

endpackage

// File: rtl/alu_flag_stage_if.sv
// Upstream (adder taps + valid/ready) and downstream (result/flags + valid/ready)
// bundle for alu_flag_stage. The stage is the slave; the adder/consumer side is master.
interface alu_flag_stage_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0]  in_sum;
  logic              in_c_out;
  logic              in_c3;
  logic              in_c2;
  logic              in_resta;
  logic              in_valid;
  logic              in_ready;

  logic [WIDTH-1:0]  out_result;
  logic [FLAG_W-1:0] out_flags;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_sum, in_c_out, in_c3, in_c2, in_resta, in_valid,
    input  in_ready,
    input  out_result, out_flags, out_valid,
    output out_ready
  );

  modport slave (
    input  in_sum, in_c_out, in_c3, in_c2, in_resta, in_valid,
    output in_ready,
    output out_result, out_flags, out_valid,
    input  out_ready
  );

endinterface

// File: rtl/alu_flag_stage_calc.sv
// Combinational N/Z/C/V derivation from the adder sum and carry taps, plus the
// half-carry tap reserved for BCD adjust.
module alu_flag_calc
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] sum_i,
  input  logic             c_out_i,
  input  logic             c3_i,
  input  logic             c2_i,
  output flags_t           flags_o,
  output logic             h_o
);

  // C is the raw carry out: after a subtraction 1 means "no borrow".
  always_comb begin
    flags_o.n = sum_i[WIDTH-1];
    flags_o.z = (sum_i == '0);
    flags_o.c = c_out_i;
    flags_o.v = signed_ovf(c_out_i, c3_i);
  end

  assign h_o = c2_i;

endmodule

// File: rtl/alu_flag_stage.sv
// Registered flag stage behind the add/subtract unit: 2-entry skid buffer with
// valid/ready on both sides. Optional sticky overflow under ALU_FLAG_STICKY_EN.
module alu_flag_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_flag_stage_if.slave   bus,
  input  logic              sticky_clr,
  output logic              out_v_sticky
);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    flags_t           flags;
    logic             resta;
`ifdef ALU_FLAG_STICKY_EN
    logic             h;
`endif
  } entry_t;

  flags_t     calc_flags;
  logic       calc_h;
  entry_t     new_entry;
  entry_t     head_q, head_d;
  entry_t     skid_q, skid_d;
  buf_state_e state_q, state_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       push, pop;

  alu_flag_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .sum_i   (bus.in_sum),
    .c_out_i (bus.in_c_out),
    .c3_i    (bus.in_c3),
    .c2_i    (bus.in_c2),
    .flags_o (calc_flags),
    .h_o     (calc_h)
  );

  always_comb begin
    new_entry       = '0;
    new_entry.sum   = bus.in_sum;
    new_entry.flags = calc_flags;
    new_entry.resta = bus.in_resta;
`ifdef ALU_FLAG_STICKY_EN
    new_entry.h     = calc_h;
`endif
  end

  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid_q & bus.out_ready;

  // Head is always what the outputs show; skid only fills while head is stalled.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          skid_d  = new_entry;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Skid contents are never observed before being overwritten, so no reset.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = head_q.sum;
  assign bus.out_flags  = head_q.flags;

`ifdef ALU_FLAG_STICKY_EN
  logic v_sticky_q, v_sticky_d;

  // Set has priority over clear so a concurrent overflow is never lost.
  always_comb begin
    v_sticky_d = v_sticky_q;
    if (sticky_clr)            v_sticky_d = 1'b0;
    if (push && calc_flags.v)  v_sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_sticky_q <= 1'b0;
    else        v_sticky_q <= v_sticky_d;
  end

  assign out_v_sticky = v_sticky_q;

  logic unused_entry_bits;
  assign unused_entry_bits = ^{head_q.resta, head_q.h};
`else
  assign out_v_sticky = 1'b0;

  logic unused_entry_bits;
  assign unused_entry_bits = ^{head_q.resta, sticky_clr, calc_h};
`endif

endmodule

// File: tb/tb_alu_flag_stage.sv
// Directed bench for alu_flag_stage: reset, flag derivation, backpressure,
// streaming, asynchronous mid-transfer reset and (if enabled) sticky overflow.
module tb_alu_flag_stage;

  logic clk;
  logic rst_n;
  logic sticky_clr;
  logic out_v_sticky;

  int n_chk;
  int n_fail;

  alu_flag_stage_if #(.WIDTH(4)) bus ();

  alu_flag_stage #(
    .WIDTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .sticky_clr   (sticky_clr),
    .out_v_sticky (out_v_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [3:0] s, input logic co,
                       input logic c3, input logic r);
    bus.in_valid = vld;
    bus.in_sum   = s;
    bus.in_c_out = co;
    bus.in_c3    = c3;
    bus.in_c2    = 1'b0;
    bus.in_resta = r;
  endtask

  function automatic logic [3:0] exp_flags(input logic [3:0] s, input logic co, input logic c3);
    return {s[3], (s == 4'd0), co, co ^ c3};
  endfunction

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    sticky_clr = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Reset state
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_result",    32'(bus.out_result), 32'd0);
    chk("rst_flags",     32'(bus.out_flags), 32'd0);
    chk("rst_sticky",    32'(out_v_sticky),  32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);

    // 5 + 3 = 8: N=1 Z=0 C=0 V=1
    drive(1'b1, 4'b1000, 1'b0, 1'b1, 1'b0);
    step();
    chk("add_out_valid", 32'(bus.out_valid),  32'd1);
    chk("add_result",    32'(bus.out_result), 32'h8);
    chk("add_flags",     32'(bus.out_flags),  32'b1001);
    chk("add_in_ready",  32'(bus.in_ready),   32'd1);

    // 3 - 3 = 0 with push+pop in ONE: N=0 Z=1 C=1 V=0
    bus.out_ready = 1'b1;
    drive(1'b1, 4'b0000, 1'b1, 1'b1, 1'b1);
    step();
    chk("sub_out_valid", 32'(bus.out_valid),  32'd1);
    chk("sub_result",    32'(bus.out_result), 32'h0);
    chk("sub_flags",     32'(bus.out_flags),  32'b0110);
    drive(1'b0, 4'hF, 1'b1, 1'b0, 1'b0);
    step();
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
`ifndef ALU_FLAG_STICKY_EN
    chk("sticky_tied_low", 32'(out_v_sticky), 32'd0);
`endif

    // Backpressure: 1, 2 fill the buffer, 3 waits upstream
    bus.out_ready = 1'b0;
    drive(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    step();
    chk("bp1_in_ready", 32'(bus.in_ready),   32'd1);
    chk("bp1_result",   32'(bus.out_result), 32'd1);
    drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    step();
    chk("bp2_in_ready", 32'(bus.in_ready),   32'd0);
    chk("bp2_result",   32'(bus.out_result), 32'd1);
    drive(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    step();
    chk("bp3_in_ready", 32'(bus.in_ready),   32'd0);
    chk("bp3_result",   32'(bus.out_result), 32'd1);
    chk("bp3_valid",    32'(bus.out_valid),  32'd1);
    bus.out_ready = 1'b1;
    step();
    chk("bp_pop1_result",   32'(bus.out_result), 32'd2);
    chk("bp_pop1_in_ready", 32'(bus.in_ready),   32'd1);
    step();
    chk("bp_pop2_result", 32'(bus.out_result), 32'd3);
    chk("bp_pop2_valid",  32'(bus.out_valid),  32'd1);
    bus.in_valid = 1'b0;
    step();
    chk("bp_empty_valid", 32'(bus.out_valid), 32'd0);

    // Streaming: one result per cycle, in_ready never drops
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] s;
      logic co, c3;
      s  = 4'(i);
      co = s[2];
      c3 = s[0];
      drive(1'b1, s, co, c3, s[1]);
      step();
      chk("stream_result",   32'(bus.out_result), 32'(s));
      chk("stream_flags",    32'(bus.out_flags),  32'(exp_flags(s, co, c3)));
      chk("stream_valid",    32'(bus.out_valid),  32'd1);
      chk("stream_in_ready", 32'(bus.in_ready),   32'd1);
    end
    bus.in_valid = 1'b0;
    step();
    chk("stream_end_valid", 32'(bus.out_valid), 32'd0);

    // Mid-operation asynchronous reset with the buffer full
    bus.out_ready = 1'b0;
    drive(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    step();
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid),  32'd0);
    chk("arst_in_ready",  32'(bus.in_ready),   32'd1);
    chk("arst_result",    32'(bus.out_result), 32'd0);
    chk("arst_flags",     32'(bus.out_flags),  32'd0);
    #2;
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    step();
    chk("post_rst_valid2", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 4'd9, 1'b1, 1'b0, 1'b1);
    step();
    chk("post_rst_result", 32'(bus.out_result), 32'd9);
    chk("post_rst_flags",  32'(bus.out_flags),  32'b1011);
    bus.in_valid = 1'b0;
    step();
    chk("post_rst_drain", 32'(bus.out_valid), 32'd0);

`ifdef ALU_FLAG_STICKY_EN
    // Sticky overflow: set on V push, survives V=0 pushes, set beats clear
    drive(1'b1, 4'b1000, 1'b0, 1'b1, 1'b0);
    step();
    chk("sticky_set", 32'(out_v_sticky), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(i + 1), 1'b0, 1'b0, 1'b0);
      step();
      chk("sticky_hold", 32'(out_v_sticky), 32'd1);
    end
    sticky_clr = 1'b1;
    drive(1'b1, 4'b1000, 1'b0, 1'b1, 1'b0);
    step();
    chk("sticky_set_wins", 32'(out_v_sticky), 32'd1);
    bus.in_valid = 1'b0;
    step();
    chk("sticky_clear", 32'(out_v_sticky), 32'd0);
    sticky_clr = 1'b0;
    drive(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    step();
    chk("sticky_stays_clear", 32'(out_v_sticky), 32'd0);
    bus.in_valid = 1'b0;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
